// File: rtl/m16_pkg.sv
// Shared M16 telemetry definitions, used by both the framer and the decoder.
package m16_pkg;
  localparam int M16_WORD_W = 12;
  localparam int M16_ADDR_W = 11;
  localparam logic [M16_WORD_W-1:0] M16_SYNC_DEFAULT = 12'hE2B;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCK} m16_state_e;

  typedef struct packed {
    logic [M16_WORD_W-1:0] word;
    logic [M16_ADDR_W-1:0] addr;
  } m16_wr_t;
endpackage

// File: rtl/m16_sync_detect.sv
// M16 receive shift register plus frame-marker comparator. word/hit reflect the
// value the register will hold after the current strobe, so callers act on it in the same cycle.
module m16_sync_detect
  import m16_pkg::*;
#(
  parameter logic [M16_WORD_W-1:0] SYNC_WORD = M16_SYNC_DEFAULT
) (
  input  logic                  clk80MHz,
  input  logic                  rst,
  input  logic                  bitEn,
  input  logic                  dataBit,
  output logic [M16_WORD_W-1:0] word,
  output logic                  hit
);
  logic [M16_WORD_W-1:0] sr;

  assign word = {sr[M16_WORD_W-2:0], dataBit};
  assign hit  = (word == SYNC_WORD);

  always_ff @(posedge clk80MHz or posedge rst) begin
    if (rst)        sr <= '0;
    else if (bitEn) sr <= word;
  end
endmodule

// File: rtl/m16_decoder.sv
// M16 serial frame decoder: HUNT/VERIFY/LOCK frame sync with flywheel, word write port.
// Define M16_DEC_STATS_EN to add the saturating oErrCnt port and an internal lock-loss count.
module m16_decoder
  import m16_pkg::*;
#(
  parameter logic [M16_WORD_W-1:0] SYNC_WORD     = M16_SYNC_DEFAULT,
  parameter int                    FRAME_WORDS   = 2048,
  parameter int                    VERIFY_FRAMES = 2,
  parameter int                    MISS_MAX      = 3
) (
  input  logic                  clk80MHz,
  input  logic                  rst,
  input  logic                  iBitEn,
  input  logic                  iBit,
  output logic [M16_WORD_W-1:0] oWord,
  output logic [M16_ADDR_W-1:0] oAddr,
  output logic                  oWE,
  output logic                  oFrameStart,
  output logic                  oLock,
  output logic                  oSyncErr
`ifdef M16_DEC_STATS_EN
  ,
  output logic [7:0]            oErrCnt
`endif
);
  localparam logic [M16_ADDR_W-1:0] LAST_ADDR = M16_ADDR_W'(FRAME_WORDS - 1);
  localparam logic [7:0]            VF_N      = 8'(VERIFY_FRAMES);
  localparam logic [7:0]            MM_N      = 8'(MISS_MAX);

  if (FRAME_WORDS < 2 || FRAME_WORDS > 2048 || VERIFY_FRAMES < 1 || VERIFY_FRAMES > 255 ||
      MISS_MAX < 1 || MISS_MAX > 255) begin : gBadParam
    $error("m16_decoder: parameter out of range");
  end

  m16_state_e            state;
  logic [3:0]            bitCnt;
  logic [M16_ADDR_W-1:0] wordCnt;
  logic [7:0]            hitCnt, missCnt;
  logic [M16_WORD_W-1:0] curWord;
  logic                  hit;
  m16_wr_t               wr;

  m16_sync_detect #(.SYNC_WORD(SYNC_WORD)) uSync (
    .clk80MHz(clk80MHz), .rst(rst), .bitEn(iBitEn), .dataBit(iBit), .word(curWord), .hit(hit)
  );

  // Word-complete decode shared by the FSM, write port and statistics.
  logic wordDone, atMarker, syncMiss, lockLost, doWrite;
  assign wordDone = iBitEn && (bitCnt == 4'd11) && (state != HUNT);
  assign atMarker = wordDone && (wordCnt == '0);
  assign syncMiss = atMarker && !hit;
  assign lockLost = syncMiss && (state == LOCK) && (missCnt + 8'd1 >= MM_N);
  assign doWrite  = wordDone && (((state == LOCK) && !lockLost) ||
                    ((state == VERIFY) && atMarker && hit && (hitCnt + 8'd1 >= VF_N)));

  assign oWord = wr.word;
  assign oAddr = wr.addr;

  always_ff @(posedge clk80MHz or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      bitCnt      <= '0;
      wordCnt     <= '0;
      hitCnt      <= '0;
      missCnt     <= '0;
      wr          <= '0;
      oWE         <= 1'b0;
      oFrameStart <= 1'b0;
      oLock       <= 1'b0;
      oSyncErr    <= 1'b0;
    end else begin
      oWE         <= doWrite;
      oFrameStart <= doWrite && (wordCnt == '0);
      oSyncErr    <= syncMiss;
      if (doWrite) begin
        wr.word <= curWord;
        wr.addr <= wordCnt;
      end
      if (iBitEn) begin
        if (state != HUNT) begin
          bitCnt <= (bitCnt == 4'd11) ? 4'd0 : bitCnt + 4'd1;
          if (bitCnt == 4'd11) wordCnt <= (wordCnt == LAST_ADDR) ? '0 : wordCnt + 11'd1;
        end
        case (state)
          HUNT: if (hit) begin
            // The marker just seen is word 0; the next bit starts word 1.
            state   <= VERIFY;
            bitCnt  <= 4'd0;
            wordCnt <= 11'd1;
            hitCnt  <= 8'd1;
          end
          VERIFY: if (atMarker) begin
            if (hit) begin
              hitCnt <= hitCnt + 8'd1;
              if (doWrite) begin
                state   <= LOCK;
                oLock   <= 1'b1;
                missCnt <= '0;
              end
            end else begin
              state <= HUNT;
            end
          end
          LOCK: if (atMarker) begin
            if (hit) missCnt <= '0;
            else if (lockLost) begin
              state <= HUNT;
              oLock <= 1'b0;
            end else missCnt <= missCnt + 8'd1;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef M16_DEC_STATS_EN
  logic [7:0]  errCnt;
  logic [15:0] lockLossCnt;
  assign oErrCnt = errCnt;

  // Counts the miss in the same cycle oSyncErr is raised, so both change together.
  always_ff @(posedge clk80MHz or posedge rst) begin
    if (rst) begin
      errCnt      <= '0;
      lockLossCnt <= '0;
    end else begin
      if (syncMiss && errCnt != 8'hFF) errCnt <= errCnt + 8'd1;
      if (lockLost && lockLossCnt != 16'hFFFF) lockLossCnt <= lockLossCnt + 16'd1;
    end
  end
`endif
endmodule

// File: doc/m16_decoder.md
# m16_decoder

Receive-side counterpart of the M16 orbital telemetry framer: takes the serial M16 bit stream (the signal driven on `orbFrame`), acquires frame sync, and delivers 12-bit orbit words with their frame addresses. Writes go into an `ramM16`-style buffer for loopback self-test and ground-side checkout. The block sits in the `clk80MHz` domain. An external bit-recovery stage supplies one enable strobe per received bit.

## Interface
Parameters:
- `SYNC_WORD`, default 12'hE2B: frame marker, carried as word 0 of every frame.
- `FRAME_WORDS`, default 2048: number of words per frame, including the marker.
- `VERIFY_FRAMES`, default 2: number of consecutive marker hits needed to declare lock.
- `MISS_MAX`, default 3: number of consecutive marker misses in lock that drop lock.

Ports:
- `clk80MHz`  in  1  — single clock.
- `rst`  in  1  — asynchronous, active-high reset.
- `iBitEn`  in  1  — one-cycle strobe; `iBit` is valid in that cycle.
- `iBit`  in  1  — serial data, MSB of each word first.
- `oWord`  out  12  — received word.
- `oAddr`  out  11  — word index within the frame (0 = marker).
- `oWE`  out  1  — one-cycle write strobe for `oWord`/`oAddr`.
- `oFrameStart`  out  1  — one-cycle pulse with the `oWE` for address 0.
- `oLock`  out  1  — level; high in LOCK state.
- `oSyncErr`  out  1  — one-cycle pulse on every marker miss while in VERIFY or LOCK.
- `oErrCnt`  out  8  — present only with `M16_DEC_STATS_EN`.

## Operation
- 12-bit shift register; it loads `{sr[10:0], iBit}` on each `iBitEn`. A bit counter (0..11) and a word counter (0..FRAME_WORDS-1) track position once aligned.
- **HUNT** (reset state):
  - Compares the shift register against `SYNC_WORD` after every bit.
  - On a hit: go to VERIFY; set bit counter to 0 and word counter to 1; hit counter = 1.
  - No writes.
- **VERIFY**:
  - Counts words without writing.
  - At each word-0 boundary, compares the completed word with `SYNC_WORD`.
  - Hit: increment the hit counter. When it reaches `VERIFY_FRAMES`, go to LOCK. The marker that completes verification is written as address 0.
  - Miss: pulse `oSyncErr` and return to HUNT. The shift register is kept, so the next bit resumes the search.
- **LOCK**:
  - Each completed word is written: `oWord` = shift register, `oAddr` = word counter.
  - At word 0, check the marker:
    - Hit: clear the miss counter.
    - Miss: pulse `oSyncErr` and increment the miss counter. At `MISS_MAX` go to HUNT, with no write of that word.
    - Below `MISS_MAX`, stay locked (flywheel) and still write the word at address 0.
- The word counter wraps from FRAME_WORDS-1 to 0. No wrap beyond 11 bits; FRAME_WORDS ≤ 2048 is enforced by elaboration check.
- An `iBitEn` gap of any length is legal; state is held.

## Timing
- Reset values:
  - all outputs 0;
  - state HUNT;
  - shift register, bit/word/hit/miss counters 0.
- `oWE`, `oWord`, `oAddr` and `oFrameStart` are registered. They are valid in the cycle after the `iBitEn` that carried the word's LSB. `oWord`/`oAddr` hold until the next write.
- `oLock` rises in the same cycle as the first address-0 `oWE`. It falls in the cycle after the final failing marker's LSB strobe.
- `oSyncErr` has the same one-cycle latency as `oWE`.
- Back-to-back `iBitEn` (every cycle) is supported at full rate.
- Asserting `rst` mid-frame clears everything immediately, including an in-flight `oWE`.

## Configuration
- `M16_DEC_STATS_EN` defined:
  - Adds `oErrCnt`, a saturating (stops at 255) count of `oSyncErr` pulses since reset.
  - Adds a lock-loss count that is internal only and readable in simulation.
- Undefined: the `oErrCnt` port and counters are absent. All other behaviour is identical.

## Structure
- Shared package `m16_pkg`:
  - `M16_WORD_W` = 12, `M16_ADDR_W` = 11, `M16_SYNC_DEFAULT`;
  - state enum `{HUNT, VERIFY, LOCK}`.
  - The M16 framer uses the same package.
- One natural sub-module, `m16_sync_detect`: shift register plus marker comparator. It outputs `hit` and the current word. The FSM, counters and write port stay in `m16_decoder`.

## Test plan
- Clean stream: reset, then 3 frames with marker 12'hE2B and word n = n[11:0]:
  - frame 1 → HUNT→VERIFY, no writes;
  - frame 2 → LOCK, `oFrameStart` with address 0;
  - then 2048 writes per frame, `oWord` == `oAddr` for addresses 1..2047.
- Bit-slip acquisition: 5 garbage bits precede a valid stream → lock after 2 markers; first written word = 12'hE2B at address 0.
- Single corrupt marker in LOCK (12'hE2A) → one `oSyncErr`; `oLock` stays 1; the frame is written in full.
- Three consecutive corrupt markers → `oSyncErr` ×3, `oLock` falls after the third; no write of that word-0; returns to HUNT.
- Sparse strobes: `iBitEn` every 7th cycle with random gaps → word sequence identical to the full-rate run.
- Reset mid-frame (address 1000) → all outputs 0 next cycle, state HUNT. With `M16_DEC_STATS_EN`: `oErrCnt` increments per miss and saturates at 255 after 300 misses.
